// File: rtl/pass_detector.sv
// Game-rule stage for the score counter. Each tick it checks the bird against the pipe in its column.
// Each cleared pipe holds win high for exactly WIN_HOLD clocks, and clears that overlap a window are queued.
module pass_detector #(
  parameter int ROWS     = 8,
  parameter int WIN_HOLD = 1024,
  parameter int PEND_MAX = 7
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic            tick,
  input  logic [ROWS-1:0] bird_row,
  input  logic [ROWS-1:0] pipe_col,
  output logic            win,
  output logic            die,
  output logic            playing
);

  localparam int HW = $clog2(WIN_HOLD + 1);
  localparam int PW = $clog2(PEND_MAX + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(WIN_HOLD);
  localparam logic [PW-1:0] PEND_FULL = PW'(PEND_MAX);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    DEAD
  } state_t;

  state_t        state;
  logic          start_q;
  logic          in_pipe;
  logic [PW-1:0] pend;
  logic [HW-1:0] hold;

  logic start_rise;
  logic collide;
  logic pass;

  assign start_rise = start & ~start_q;
  assign collide    = (bird_row == '0) || ((bird_row & pipe_col) != '0);
  // A clear is the first pipe-free tick after the bird has been inside a gap.
  assign pass       = (state == PLAY) && tick && !collide && (pipe_col == '0) && in_pipe;

  // In IDLE and DEAD only start_rise matters. Ticks in those states are never evaluated.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      start_q <= 1'b0;
      in_pipe <= 1'b0;
      pend    <= '0;
      hold    <= '0;
    end else begin
      start_q <= start;
      case (state)
        IDLE, DEAD: begin
          if (start_rise) begin
            state   <= PLAY;
            in_pipe <= 1'b0;
            pend    <= '0;
            hold    <= '0;
          end
        end
        PLAY: begin
          if (tick && collide) begin
            state <= DEAD;
            pend  <= '0;
            hold  <= '0;
          end else begin
            if (tick && (pipe_col != '0)) begin
              in_pipe <= 1'b1;
            end else if (pass) begin
              in_pipe <= 1'b0;
            end
            // When the last clock of a window is reached, a queued clear starts the next window with no gap.
            if (hold > HW'(1)) begin
              hold <= hold - HW'(1);
              if (pass && (pend != PEND_FULL)) begin
                pend <= pend + PW'(1);
              end
            end else if (pend != '0) begin
              hold <= HOLD_LOAD;
              if (!pass) begin
                pend <= pend - PW'(1);
              end
            end else if (pass) begin
              hold <= HOLD_LOAD;
            end else begin
              hold <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign win     = (hold != '0);
  assign die     = (state == DEAD);
  assign playing = (state == PLAY);

endmodule

// File: tb/tb_pass_detector.sv
// Directed bench for pass_detector. The stimulus side queues each expected win pulse (rise cycle, length).
// The monitor measures every real pulse and checks it against the queue.
module tb_pass_detector;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       tick;
  logic [7:0] birdRow;
  logic [7:0] pipeCol;
  logic       win;
  logic       die;
  logic       playing;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lastTickCyc = 0;
  int riseCyc = 0;
  logic winPrev = 1'b0;

  typedef struct {
    int rise;
    int len;
  } pulse_t;

  pulse_t expQ[$];
  pulse_t monP;

  pass_detector #(
    .ROWS(8),
    .WIN_HOLD(1024),
    .PEND_MAX(7)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .tick(tick),
    .bird_row(birdRow),
    .pipe_col(pipeCol),
    .win(win),
    .die(die),
    .playing(playing)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic expWin, input logic expDie,
                             input logic expPlay);
    checkInt({name, ".win"}, int'(win), int'(expWin));
    checkInt({name, ".die"}, int'(die), int'(expDie));
    checkInt({name, ".playing"}, int'(playing), int'(expPlay));
  endtask

  // The monitor watches win at every falling clock edge. When a pulse ends, it takes the oldest expected pulse from the queue and compares.
  always @(negedge clock) begin
    if (win && !winPrev) riseCyc = cyc;
    if (!win && winPrev) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedPulse: got rise %0d len %0d expected none", riseCyc,
                 cyc - riseCyc);
      end else begin
        monP = expQ.pop_front();
        checkInt("pulseRise", riseCyc, monP.rise);
        checkInt("pulseLen", cyc - riseCyc, monP.len);
      end
    end
    winPrev = win;
  end

  task automatic applyStimulus(input logic [7:0] bird, input logic [7:0] pipe,
                               input logic withStart);
    @(negedge clock);
    tick        = 1'b1;
    start       = withStart;
    birdRow     = bird;
    pipeCol     = pipe;
    lastTickCyc = cyc;
    @(negedge clock);
    tick  = 1'b0;
    start = 1'b0;
  endtask

  task automatic pressStart();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic clearPipe();
    applyStimulus(8'h08, 8'hE7, 1'b0);
    applyStimulus(8'h08, 8'h00, 1'b0);
  endtask

  task automatic expectPulse(input int len);
    pulse_t p;
    p.rise = lastTickCyc + 1;
    p.len  = len;
    expQ.push_back(p);
  endtask

  task automatic waitWinLow(input string name, input int limit);
    bit done = 1'b0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clock);
      if (!win) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s: got win still high after %0d clocks expected low", name, limit);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    tick    = 1'b0;
    birdRow = '0;
    pipeCol = '0;
    repeat (3) @(negedge clock);
    checkOutput("resetState", 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("idle", 1'b0, 1'b0, 1'b0);

    // single clear gives one full window
    pressStart();
    checkOutput("startPlay", 1'b0, 1'b0, 1'b1);
    clearPipe();
    expectPulse(1024);
    checkOutput("clearWin", 1'b1, 1'b0, 1'b1);
    waitWinLow("singleWindow", 1100);

    // collision during a window kills win the same cycle die rises
    clearPipe();
    expectPulse(21);
    repeat (19) @(negedge clock);
    applyStimulus(8'h40, 8'hE7, 1'b0);
    checkOutput("collide", 1'b0, 1'b1, 1'b0);
    pressStart();
    checkOutput("restart", 1'b0, 1'b0, 1'b1);
    pressStart();
    checkOutput("startInPlay", 1'b0, 1'b0, 1'b1);

    // three spaced clears form one contiguous pulse
    clearPipe();
    expectPulse(3072);
    repeat (96) @(negedge clock);
    clearPipe();
    repeat (96) @(negedge clock);
    clearPipe();
    checkOutput("threeClears", 1'b1, 1'b0, 1'b1);
    waitWinLow("threeWindows", 3200);

    // ten clears inside one window saturate the queue at seven
    clearPipe();
    expectPulse(8192);
    repeat (9) clearPipe();
    waitWinLow("burstWindows", 8400);
    checkOutput("afterBurst", 1'b0, 1'b0, 1'b1);
    clearPipe();
    expectPulse(1024);
    waitWinLow("postBurstWindow", 1100);

    // asynchronous reset while win is high
    clearPipe();
    expectPulse(9);
    repeat (8) @(negedge clock);
    #1 reset = 1'b0;
    #1 checkOutput("asyncReset", 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("afterReset", 1'b0, 1'b0, 1'b0);

    // ticks are ignored in IDLE, bird off screen kills in PLAY
    applyStimulus(8'h40, 8'hE7, 1'b0);
    checkOutput("idleTickCollide", 1'b0, 1'b0, 1'b0);
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("idleTickOffscreen", 1'b0, 1'b0, 1'b0);
    pressStart();
    applyStimulus(8'h00, 8'h00, 1'b0);
    checkOutput("offscreenDie", 1'b0, 1'b1, 1'b0);

    // start and colliding tick together in DEAD: only the restart happens
    applyStimulus(8'h40, 8'hE7, 1'b1);
    checkOutput("startWithTick", 1'b0, 1'b0, 1'b1);

    // entering PLAY forgets a gap the bird was in before dying
    applyStimulus(8'h08, 8'hE7, 1'b0);
    applyStimulus(8'h40, 8'hE7, 1'b0);
    checkOutput("dieInGap", 1'b0, 1'b1, 1'b0);
    pressStart();
    applyStimulus(8'h08, 8'h00, 1'b0);
    repeat (2) @(negedge clock);
    checkOutput("noStaleClear", 1'b0, 1'b0, 1'b1);

    #1;
    checkInt("queueEmpty", int'(expQ.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
